// File: rtl/alarm_scheduler.sv
// Buzzer arbiter for the frio/quente/falha alarms: fixed-priority grant,
// beep-burst sequencing and square-wave tone generation with per-source mute.
module alarm_scheduler #(
  parameter int TONE_DIV = 5_000_000,
  parameter int ON_CYC   = 12_500_000,
  parameter int OFF_CYC  = 12_500_000,
  parameter int GAP_CYC  = 50_000_000,
  parameter int N_FRIO   = 2,
  parameter int N_QUENTE = 4,
  parameter int CW       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_frio,
  input  logic       req_quente,
  input  logic       req_falha,
  input  logic       ack,
  output logic       sinal,
  output logic [1:0] grant,
  output logic       ativo
);

  typedef enum logic [2:0] {IDLE, ON, OFF, GAP, CONT} state_t;

  localparam logic [CW-1:0] TONE_LAST = CW'(TONE_DIV - 1);
  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [7:0]    NB_FRIO   = 8'(N_FRIO);
  localparam logic [7:0]    NB_QUENTE = 8'(N_QUENTE);

  state_t        state, state_d;
  logic [1:0]    grant_d;
  logic          sinal_d;
  logic [CW-1:0] timer, timer_d;
  logic [CW-1:0] tone_cnt, tone_d;
  logic [7:0]    beep_cnt, beep_d;
  logic [2:0]    mute, mute_d;

  logic [2:0]    req_v, ack_mask, elig;
  logic [1:0]    pick, launch_src;
  logic          granted_ok, launch;
  logic [7:0]    n_cur;

  // bit 0 = frio, bit 1 = quente, bit 2 = falha
  assign req_v = {req_falha, req_quente, req_frio};

  always_comb begin
    ack_mask = 3'b000;
    if (ack) begin
      case (grant)
        2'd1:    ack_mask = 3'b001;
        2'd2:    ack_mask = 3'b010;
        2'd3:    ack_mask = 3'b100;
        default: ack_mask = 3'b000;
      endcase
    end
  end

  // An ack in this cycle already removes its source from arbitration.
  assign elig   = req_v & ~mute & ~ack_mask;
  assign mute_d = (mute & req_v) | ack_mask;
  assign n_cur  = (grant == 2'd2) ? NB_QUENTE : NB_FRIO;

  always_comb begin
    if (elig[2])      pick = 2'd3;
    else if (elig[1]) pick = 2'd2;
    else if (elig[0]) pick = 2'd1;
    else              pick = 2'd0;
  end

  always_comb begin
    case (grant)
      2'd1:    granted_ok = elig[0];
      2'd2:    granted_ok = elig[1];
      2'd3:    granted_ok = elig[2];
      default: granted_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    sinal_d    = sinal;
    timer_d    = timer;
    tone_d     = tone_cnt;
    beep_d     = beep_cnt;
    launch     = 1'b0;
    launch_src = pick;

    if (state != IDLE && !granted_ok) begin
      state_d = IDLE;
      grant_d = 2'd0;
      sinal_d = 1'b0;
      timer_d = '0;
      tone_d  = '0;
      beep_d  = '0;
    end else if ((grant == 2'd1 || grant == 2'd2) && elig[2]) begin
      launch     = 1'b1;
      launch_src = 2'd3;
    end else begin
      case (state)
        IDLE: launch = 1'b1;
        ON: begin
          if (tone_cnt == TONE_LAST) begin
            tone_d  = '0;
            sinal_d = ~sinal;
          end else begin
            tone_d = tone_cnt + 1'b1;
          end
          if (timer == ON_LAST) begin
            timer_d = '0;
            tone_d  = '0;
            sinal_d = 1'b0;
            state_d = (beep_cnt < n_cur) ? OFF : GAP;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
        OFF: begin
          if (timer == OFF_LAST) begin
            timer_d = '0;
            tone_d  = '0;
            sinal_d = 1'b1;
            beep_d  = beep_cnt + 8'd1;
            state_d = ON;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) launch = 1'b1;
          else                   timer_d = timer + 1'b1;
        end
        CONT: begin
          if (tone_cnt == TONE_LAST) begin
            tone_d  = '0;
            sinal_d = ~sinal;
          end else begin
            tone_d = tone_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Start a fresh pattern for the winning source (or fall back to IDLE).
    if (launch) begin
      timer_d = '0;
      tone_d  = '0;
      grant_d = launch_src;
      case (launch_src)
        2'd3: begin
          state_d = CONT;
          sinal_d = 1'b1;
          beep_d  = '0;
        end
        2'd1, 2'd2: begin
          state_d = ON;
          sinal_d = 1'b1;
          beep_d  = 8'd1;
        end
        default: begin
          state_d = IDLE;
          sinal_d = 1'b0;
          beep_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 2'd0;
      ativo    <= 1'b0;
      sinal    <= 1'b0;
      timer    <= '0;
      tone_cnt <= '0;
      beep_cnt <= '0;
      mute     <= 3'b000;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      ativo    <= (grant_d != 2'd0);
      sinal    <= sinal_d;
      timer    <= timer_d;
      tone_cnt <= tone_d;
      beep_cnt <= beep_d;
      mute     <= mute_d;
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with TONE_DIV=2, ON=8, OFF=4, GAP=16.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst, req_frio, req_quente, req_falha, ack;
  logic       sinal, ativo;
  logic [1:0] grant;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .TONE_DIV(2), .ON_CYC(8), .OFF_CYC(4), .GAP_CYC(16),
    .N_FRIO(2), .N_QUENTE(4), .CW(26)
  ) dut (
    .clk(clk), .rst(rst), .req_frio(req_frio), .req_quente(req_quente),
    .req_falha(req_falha), .ack(ack), .sinal(sinal), .grant(grant), .ativo(ativo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic s, input logic [1:0] g);
    chk({tag, ".sinal"}, 32'(sinal), 32'(s));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".ativo"}, 32'(ativo), 32'(g != 2'd0));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Tone inside an ON/CONT window: 1,1,0,0,1,1,0,0...
  function automatic logic tone_at(input int m);
    return ((m / 2) % 2) == 0;
  endfunction

  // quente burst: ON at 0,12,24,36 (8 cycles each), GAP 44..59, period 60
  function automatic logic quente_sinal(input int k);
    int p;
    p = k % 60;
    return (p < 44 && (p % 12) < 8) ? tone_at(p % 12) : 1'b0;
  endfunction

  // frio burst: ON at 0,12 (8 cycles each), GAP 20..35, period 36
  function automatic logic frio_sinal(input int k);
    int p;
    p = k % 36;
    return (p < 20 && (p % 12) < 8) ? tone_at(p % 12) : 1'b0;
  endfunction

  initial begin
    rst = 1'b1; req_frio = 1'b0; req_quente = 1'b0; req_falha = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 expect_out("reset", 1'b0, 2'd0);
    rst = 1'b0;
    tick;
    expect_out("idle", 1'b0, 2'd0);

    // quente held: two full bursts
    req_quente = 1'b1;
    tick;
    for (int k = 0; k < 120; k++) begin
      expect_out($sformatf("quente[%0d]", k), quente_sinal(k), 2'd2);
      tick;
    end
    tick;
    expect_out("pre_rst", 1'b1, 2'd2);
    #2 rst = 1'b1;
    #1 expect_out("rst_async", 1'b0, 2'd0);
    #2 rst = 1'b0;
    tick;
    for (int k = 0; k < 12; k++) begin
      expect_out($sformatf("rst_restart[%0d]", k), quente_sinal(k), 2'd2);
      tick;
    end

    // ack mutes quente until its request is re-asserted
    ack = 1'b1;
    tick;
    ack = 1'b0;
    expect_out("ack", 1'b0, 2'd0);
    for (int k = 0; k < 10; k++) begin
      tick;
      expect_out($sformatf("muted[%0d]", k), 1'b0, 2'd0);
    end
    req_quente = 1'b0;
    tick;
    expect_out("req_low", 1'b0, 2'd0);
    req_quente = 1'b1;
    tick;
    expect_out("regrant", 1'b1, 2'd2);
    req_quente = 1'b0;
    tick;
    expect_out("drop", 1'b0, 2'd0);

    // frio held, then falha preempts mid-ON
    req_frio = 1'b1;
    tick;
    for (int k = 0; k < 75; k++) begin
      expect_out($sformatf("frio[%0d]", k), frio_sinal(k), 2'd1);
      tick;
    end
    req_falha = 1'b1;
    tick;
    for (int m = 0; m < 12; m++) begin
      expect_out($sformatf("cont[%0d]", m), tone_at(m), 2'd3);
      tick;
    end
    req_falha = 1'b0;
    tick;
    expect_out("falha_drop", 1'b0, 2'd0);
    tick;
    for (int k = 0; k < 35; k++) begin
      expect_out($sformatf("frio_restart[%0d]", k), frio_sinal(k), 2'd1);
      tick;
    end

    // ack on the last GAP cycle: mute wins over re-arbitration
    ack = 1'b1;
    tick;
    ack = 1'b0;
    expect_out("ack_gap", 1'b0, 2'd0);
    tick;
    expect_out("ack_gap_hold", 1'b0, 2'd0);
    req_frio = 1'b0;
    tick;
    expect_out("frio_low", 1'b0, 2'd0);

    // simultaneous rise: quente wins, drop it in GAP, frio follows
    req_frio = 1'b1;
    req_quente = 1'b1;
    tick;
    for (int k = 0; k < 50; k++) begin
      expect_out($sformatf("tie[%0d]", k), quente_sinal(k), 2'd2);
      tick;
    end
    req_quente = 1'b0;
    tick;
    expect_out("drop_gap", 1'b0, 2'd0);
    tick;
    expect_out("frio_after", 1'b1, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
